// File: rtl/market_data_bram_streamer_pkg.sv
// Shared constants and FSM encoding for the market-data BRAM streamer.
// Row layout: timestamp followed by OHLCV as IEEE-754 singles.
package market_data_pkg;
    localparam int DATA_W    = 32;
    localparam int NUM_COLS  = 6;

    localparam int COL_TS    = 0;
    localparam int COL_OPEN  = 1;
    localparam int COL_HIGH  = 2;
    localparam int COL_LOW   = 3;
    localparam int COL_CLOSE = 4;
    localparam int COL_VOL   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } mdb_state_t;
endpackage

// File: rtl/market_data_bram_streamer_out_fifo.sv
// Two-entry skid FIFO on the stream output; head is held stable while stalled.
// Flush is synchronous, reset asynchronous.
module mdb_out_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);
    logic [W-1:0] ent0, ent1;
    logic         wptr, rptr;
    logic [1:0]   cnt;
    logic         do_pop;

    assign do_pop = pop && (cnt != 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0 <= '0;
            ent1 <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else if (flush) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
        end else begin
            if (push) begin
                if (wptr) ent1 <= push_data;
                else      ent0 <= push_data;
                wptr <= ~wptr;
            end
            if (do_pop) rptr <= ~rptr;
            cnt <= cnt + {1'b0, push} - {1'b0, do_pop};
        end
    end

    assign head  = rptr ? ent1 : ent0;
    assign valid = (cnt != 2'd0);
    assign count = cnt;
endmodule

// File: rtl/market_data_bram_streamer.sv
// Market-data row store with a write port, a registered random-read port and
// a burst engine streaming whole rows over valid/ready.
module market_data_bram_streamer #(
    parameter int    DATA_W    = market_data_pkg::DATA_W,
    parameter int    NUM_COLS  = market_data_pkg::NUM_COLS,
    parameter int    NUM_ROWS  = 1024,
    parameter int    ROW_W     = 10,
    parameter int    COL_W     = 3,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              start,
    input  logic [ROW_W-1:0]  start_row,
    input  logic [ROW_W:0]    row_count,
    input  logic              abort,
    output logic [DATA_W-1:0] m_data,
    output logic [COL_W-1:0]  m_col,
    output logic [ROW_W-1:0]  m_row,
    output logic              m_last_col,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);
    import market_data_pkg::*;

    localparam int DEPTH = NUM_ROWS * NUM_COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = DATA_W + COL_W + ROW_W + 2;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    function automatic logic [AW-1:0] lin_addr(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
        return AW'(r) * AW'(NUM_COLS) + AW'(c);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    mdb_state_t        state, state_nxt;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W:0]    rows_left;
    logic              a_vld, a_is_rd, a_last_col, a_last;
    logic [AW-1:0]     addr_q;
    logic [COL_W-1:0]  a_col;
    logic [ROW_W-1:0]  a_row;
    logic [1:0]        fifo_cnt;
    logic [FW-1:0]     fifo_head, push_data;
    logic              idle, rd_go, start_go, abort_go, issue, pop, push;
    logic              at_last_col, at_last;

    assign idle        = (state == ST_IDLE);
    assign rd_go       = idle && rd_en;
    assign start_go    = idle && !rd_en && start;
    assign abort_go    = abort && (state == ST_STREAM || state == ST_DRAIN);
    assign pop         = m_valid && m_ready;
    assign at_last_col = (cur_col == LAST_COL);
    assign at_last     = at_last_col && (rows_left == {{ROW_W{1'b0}}, 1'b1});
    // Issue only while FIFO entries plus the read in flight still fit, counting this cycle's pop.
    assign issue = (state == ST_STREAM) && !abort &&
                   ({1'b0, fifo_cnt} + {2'b0, a_vld} < 3'd2 + {2'b0, pop});

    // Read-first: the NBA write lands after the registered read samples the array.
    always_ff @(posedge clk) begin
        if (wr_en && wr_col <= LAST_COL && wr_row <= LAST_ROW)
            mem[lin_addr(wr_row, wr_col)] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_go) state_nxt = (row_count != '0) ? ST_STREAM : ST_DONE;
            ST_STREAM: if (abort) state_nxt = ST_IDLE;
                       else if (issue && at_last) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (abort) state_nxt = ST_IDLE;
                       else if (fifo_cnt == 2'd0 && !a_vld) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign busy = !idle;
    assign done = (state == ST_DONE);

    // Address stage shared by random reads and stream reads; data is captured one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_row    <= '0;
            cur_col    <= '0;
            rows_left  <= '0;
            a_vld      <= 1'b0;
            a_is_rd    <= 1'b0;
            addr_q     <= '0;
            a_col      <= '0;
            a_row      <= '0;
            a_last_col <= 1'b0;
            a_last     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (start_go) begin
                cur_row   <= start_row;
                cur_col   <= '0;
                rows_left <= row_count;
            end else if (issue) begin
                if (at_last_col) begin
                    cur_col   <= '0;
                    cur_row   <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
                    rows_left <= rows_left - 1'b1;
                end else begin
                    cur_col <= cur_col + 1'b1;
                end
            end
            a_vld   <= rd_go || issue;
            a_is_rd <= rd_go;
            if (rd_go) begin
                addr_q <= lin_addr(rd_row, rd_col);
            end else if (issue) begin
                addr_q     <= lin_addr(cur_row, cur_col);
                a_col      <= cur_col;
                a_row      <= cur_row;
                a_last_col <= at_last_col;
                a_last     <= at_last;
            end
            rd_valid <= a_vld && a_is_rd;
            if (a_vld && a_is_rd) rd_data <= mem[addr_q];
        end
    end

    assign push      = a_vld && !a_is_rd;
    assign push_data = {mem[addr_q], a_col, a_row, a_last_col, a_last};

    mdb_out_fifo #(.W(FW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort_go),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (m_valid),
        .count     (fifo_cnt)
    );

    assign {m_data, m_col, m_row, m_last_col, m_last} = fifo_head;
endmodule
